// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, character-length and parity codes.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] BITS_5 = 2'b00;
    localparam logic [1:0] BITS_6 = 2'b01;
    localparam logic [1:0] BITS_7 = 2'b10;
    localparam logic [1:0] BITS_8 = 2'b11;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    // Index of the last data bit for a character-length code (5 bits -> 4 ... 8 bits -> 7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
        return 3'(bits) + 3'd4;
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity covers only the selected character length; upper bits are masked off.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] bits,
                                        input logic [1:0] mode);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - bits);
        return (^(data & mask)) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick on the last clock of every bit (div+1 clocks per bit).
// Restart or disable clears the count so nothing carries over between frames.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    assign tick = en && (r_cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
// tx_done marks the last stop-bit clock, where a new character may be accepted back-to-back.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int   DIV_W    = 16,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       data_bits,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    uart_state_t      r_state, w_state_next;
    logic             r_tx, w_tx_next;
    logic [7:0]       r_shift, w_shift_next;
    logic [2:0]       r_bit_cnt, w_bit_cnt_next;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_bits;
    logic             r_par_en;
    logic             r_par;
    logic             r_stop2;

    logic w_tick;
    logic w_accept;
    logic w_done;
    logic w_busy;
    logic w_en;

    assign w_en     = (r_state != ST_IDLE);
    assign w_busy   = w_en && !w_done;
    assign w_accept = tx_valid && !w_busy;

    assign tx_ready = !w_busy;
    assign busy     = w_busy;
    assign tx_done  = w_done;
    assign tx       = r_tx;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_en),
        .restart (w_accept),
        .div     (r_div),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_tx_next      = r_tx;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_next = IDLE_LVL;
                if (w_accept) begin
                    w_state_next = ST_START;
                    w_tx_next    = !IDLE_LVL;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next   = ST_DATA;
                    w_tx_next      = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == last_bit_idx(r_bits)) begin
                        w_bit_cnt_next = 3'd0;
                        if (r_par_en) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_par;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = IDLE_LVL;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        w_tx_next      = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next   = ST_STOP;
                    w_tx_next      = IDLE_LVL;
                    w_bit_cnt_next = 3'd0;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stop2 && (r_bit_cnt == 3'd0)) begin
                        w_bit_cnt_next = 3'd1;
                    end else begin
                        // Last stop-bit clock: an accept here chains straight into the next start bit.
                        w_done = 1'b1;
                        if (w_accept) begin
                            w_state_next = ST_START;
                            w_tx_next    = !IDLE_LVL;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_tx_next    = IDLE_LVL;
                        end
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = IDLE_LVL;
            end
        endcase

        if (w_accept) begin
            w_shift_next   = tx_data;
            w_bit_cnt_next = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tx      <= IDLE_LVL;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div     <= '0;
            r_bits    <= BITS_5;
            r_par_en  <= 1'b0;
            r_par     <= 1'b0;
            r_stop2   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tx      <= w_tx_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            if (w_accept) begin
                r_div    <= div;
                r_bits   <= data_bits;
                r_par_en <= parity_enabled(parity_mode);
                r_par    <= parity_bit(tx_data, data_bits, parity_mode);
                r_stop2  <= stop2;
            end
        end
    end

endmodule
